// File: rtl/usb_tx_phy.sv
// USB full-speed packet transmitter: SYNC, PID, token/data fields with CRC5/CRC16,
// bit stuffing and NRZI onto D+/D-, closed by SE0 SE0 J.
module usb_tx_phy #(
    parameter int unsigned CLK_PER_BIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] pid_i,
    input  logic [6:0] addr_i,
    input  logic [3:0] endp_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       busy_o,
    output logic       tx_en_o,
    output logic       dp_tx_o,
    output logic       dn_tx_o
);

    localparam int unsigned CntW = $clog2(CLK_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle, StSync, StPid, StToken, StData, StCrc, StEopSe0, StEopJ
    } state_e;

    state_e          state_q, nxt_state;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      ones_q;
    logic [15:0]     sh_q, fld_sh;
    logic [4:0]      len_q, fld_len;
    logic [4:0]      crc5_q, crc5_nxt, crc5_out;
    logic [15:0]     crc16_q, crc16_nxt, crc16_out;
    logic [3:0]      pid_q;
    logic [6:0]      addr_q;
    logic [3:0]      endp_q;
    logic            busy_q, tx_en_q, dp_q, dn_q, ready_q;
    logic            take, to_eop, data_req, tx_bit, bit_end;

    assign bit_end = (cnt_q == CntLast);

    // CRC register MSB goes out first, so the shifter gets it bit-reversed and inverted.
    assign crc5_out  = ~{<<{crc5_q}};
    assign crc16_out = ~{<<{crc16_q}};

    // When the current field is exhausted, pick the next field and expose its first bit.
    always_comb begin
        nxt_state = state_q;
        fld_sh    = sh_q;
        fld_len   = len_q;
        take      = 1'b0;
        to_eop    = 1'b0;
        data_req  = 1'b0;
        if (len_q == 5'd0) begin
            case (state_q)
                StSync: begin
                    nxt_state = StPid;
                    fld_sh    = {8'h00, ~pid_q, pid_q};
                    fld_len   = 5'd8;
                end
                StPid: begin
                    if (pid_q[1:0] == 2'b01) begin
                        nxt_state = StToken;
                        fld_sh    = {5'b00000, endp_q, addr_q};
                        fld_len   = 5'd11;
                    end else if (pid_q[1:0] == 2'b11) begin
                        data_req = 1'b1;
                    end else begin
                        to_eop = 1'b1;
                    end
                end
                StToken: begin
                    nxt_state = StCrc;
                    fld_sh    = {11'b0, crc5_out};
                    fld_len   = 5'd5;
                end
                StData:  data_req = 1'b1;
                default: to_eop = 1'b1;
            endcase
            if (data_req) begin
                if (data_valid_i) begin
                    nxt_state = StData;
                    fld_sh    = {8'h00, data_i};
                    fld_len   = 5'd8;
                    take      = 1'b1;
                end else begin
                    nxt_state = StCrc;
                    fld_sh    = crc16_out;
                    fld_len   = 5'd16;
                end
            end
        end
    end

    assign tx_bit    = fld_sh[0];
    assign crc5_nxt  = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ tx_bit) ? 5'h05 : 5'h00);
    assign crc16_nxt = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ tx_bit) ? 16'h8005 : 16'h0000);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ones_q  <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            crc5_q  <= 5'h1F;
            crc16_q <= 16'hFFFF;
            pid_q   <= '0;
            addr_q  <= '0;
            endp_q  <= '0;
            busy_q  <= 1'b0;
            tx_en_q <= 1'b0;
            dp_q    <= 1'b1;
            dn_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            cnt_q   <= bit_end ? '0 : cnt_q + 1'b1;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (start_i) begin
                        state_q <= StSync;
                        pid_q   <= pid_i;
                        addr_q  <= addr_i;
                        endp_q  <= endp_i;
                        busy_q  <= 1'b1;
                        tx_en_q <= 1'b1;
                        // SYNC bit 0 is a zero: the line goes to K on this very edge.
                        dp_q    <= 1'b0;
                        dn_q    <= 1'b1;
                        sh_q    <= 16'h0040;
                        len_q   <= 5'd7;
                        ones_q  <= 3'd0;
                        crc5_q  <= 5'h1F;
                        crc16_q <= 16'hFFFF;
                    end
                end
                StEopSe0: begin
                    if (bit_end) begin
                        if (len_q == 5'd0) begin
                            state_q <= StEopJ;
                            dp_q    <= 1'b1;
                            dn_q    <= 1'b0;
                        end else begin
                            len_q <= len_q - 5'd1;
                        end
                    end
                end
                StEopJ: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        tx_en_q <= 1'b0;
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (ones_q == 3'd6) begin
                            dp_q   <= ~dp_q;
                            dn_q   <= ~dn_q;
                            ones_q <= 3'd0;
                        end else if (to_eop) begin
                            state_q <= StEopSe0;
                            dp_q    <= 1'b0;
                            dn_q    <= 1'b0;
                            len_q   <= 5'd1;
                        end else begin
                            state_q <= nxt_state;
                            sh_q    <= fld_sh >> 1;
                            len_q   <= fld_len - 5'd1;
                            ready_q <= take;
                            if (tx_bit) begin
                                ones_q <= ones_q + 3'd1;
                            end else begin
                                ones_q <= 3'd0;
                                dp_q   <= ~dp_q;
                                dn_q   <= ~dn_q;
                            end
                            if (nxt_state == StToken) crc5_q <= crc5_nxt;
                            if (nxt_state == StData) crc16_q <= crc16_nxt;
                        end
                    end
                end
            endcase
        end
    end

    assign data_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign tx_en_o      = tx_en_q;
    assign dp_tx_o      = dp_q;
    assign dn_tx_o      = dn_q;

endmodule
